// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, jump-select encoding and fetch-entry type for the fetch stage
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 32;
    localparam int FETCH_INSTR_W = 32;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        JC_SEQ    = 2'b00,
        JC_BRANCH = 2'b01,
        JC_JUMP   = 2'b10,
        JC_REG    = 2'b11
    } jump_ctrl_e;

    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_ADDR_W-1:0]  pc4;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular fetch queue with push, pop and single-cycle flush
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    input  logic   flush,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC register, next-PC select and decoupling queue to decode
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          INSTR_W  = 32,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               redirect,
    input  logic [1:0]         jump_ctrl,
    input  logic [ADDR_W-1:0]  branch_tgt,
    input  logic [ADDR_W-1:0]  jump_tgt,
    input  logic [ADDR_W-1:0]  reg_tgt,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc4,
    output logic               addr_err
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc4;
    } entry_t;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] sel_tgt;
    logic [ADDR_W-1:0] pc_next;
    logic              push;
    logic              pop;
    logic              q_full;
    logic              q_empty;
    entry_t            head;
    entry_t            new_entry;
    logic              addr_err_q;

    assign pc4 = pc + ADDR_W'(4);

    // An illegal select (JC_SEQ) during redirect falls through to sequential PC.
    always_comb begin
        sel_tgt = pc4;
        case (jump_ctrl)
            JC_BRANCH: sel_tgt = branch_tgt;
            JC_JUMP:   sel_tgt = jump_tgt;
            JC_REG:    sel_tgt = reg_tgt;
            default:   sel_tgt = pc4;
        endcase
    end

    assign pop  = !q_empty && out_ready && !redirect;
    assign push = en && !redirect && (!q_full || pop);

    always_comb begin
        pc_next = pc;
        if (redirect)  pc_next = {sel_tgt[ADDR_W-1:2], 2'b00};
        else if (push) pc_next = pc4;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= ADDR_W'(RESET_PC);
            addr_err_q <= 1'b0;
        end else begin
            pc         <= pc_next;
            addr_err_q <= redirect && is_misaligned(sel_tgt[1:0]);
        end
    end

    assign new_entry = '{instr: imem_rdata, pc: pc, pc4: pc4};

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (new_entry),
        .pop       (pop),
        .flush     (redirect),
        .full      (q_full),
        .empty     (q_empty),
        .head      (head)
    );

    // Stale storage is masked so an empty queue always presents zeros.
    assign imem_addr = pc;
    assign out_valid = !q_empty;
    assign out_instr = q_empty ? '0 : head.instr;
    assign out_pc    = q_empty ? '0 : head.pc;
    assign out_pc4   = q_empty ? '0 : head.pc4;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a queue-based reference model
module tb_fetch_unit;

    localparam int DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        redirect = 1'b0;
    logic [1:0]  jump_ctrl = 2'b00;
    logic [31:0] branch_tgt = '0;
    logic [31:0] jump_tgt = '0;
    logic [31:0] reg_tgt = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic        addr_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_pc = RST_PC;
    logic        m_err = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = imem_word(imem_addr);

    fetch_unit #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .redirect   (redirect),
        .jump_ctrl  (jump_ctrl),
        .branch_tgt (branch_tgt),
        .jump_tgt   (jump_tgt),
        .reg_tgt    (reg_tgt),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_pc4    (out_pc4),
        .addr_err   (addr_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare what the DUT shows now, then advance the model by the coming edge.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_pc  = RST_PC;
            m_err = 1'b0;
        end else begin
            logic        will_pop;
            logic        has_room;
            logic [31:0] tgt;
            check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
                check("out_pc",    64'(out_pc),    64'(exp_q[0].pc));
                check("out_pc4",   64'(out_pc4),   64'(exp_q[0].pc4));
            end
            check("imem_addr", 64'(imem_addr), 64'(m_pc));
            check("addr_err",  64'(addr_err),  64'(m_err));

            will_pop = (exp_q.size() != 0) && out_ready;
            has_room = exp_q.size() < DEPTH;
            if (redirect) begin
                case (jump_ctrl)
                    2'b01:   tgt = branch_tgt;
                    2'b10:   tgt = jump_tgt;
                    2'b11:   tgt = reg_tgt;
                    default: tgt = m_pc + 32'd4;
                endcase
                m_err = (tgt % 4) != 0;
                m_pc  = tgt - (tgt % 4);
                exp_q.delete();
            end else begin
                m_err = 1'b0;
                if (will_pop) void'(exp_q.pop_front());
                if (en && (has_room || will_pop)) begin
                    exp_q.push_back('{instr: imem_word(m_pc), pc: m_pc, pc4: m_pc + 32'd4});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [1:0] jc, input logic [31:0] tgt);
        redirect   = 1'b1;
        jump_ctrl  = jc;
        branch_tgt = tgt;
        jump_tgt   = tgt;
        reg_tgt    = tgt;
        step();
        redirect   = 1'b0;
        jump_ctrl  = 2'b00;
    endtask

    initial begin
        en = 1'b1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Decode stalled: two entries held, PC parked past them.
        repeat (5) step();
        check("stall_imem_addr", 64'(imem_addr), 64'h3008);
        check("stall_valid", 64'(out_valid), 64'h1);
        check("stall_head_pc", 64'(out_pc), 64'h3000);
        out_ready = 1'b1;
        repeat (6) step();

        // Redirect with a full queue.
        out_ready = 1'b0;
        repeat (3) step();
        do_redirect(2'b10, 32'h3400);
        check("redir_flush_valid", 64'(out_valid), 64'h0);
        check("redir_imem_addr", 64'(imem_addr), 64'h3400);
        out_ready = 1'b1;
        repeat (3) step();

        // Misaligned register target.
        do_redirect(2'b11, 32'h3402);
        check("misalign_pc", 64'(imem_addr), 64'h3400);
        check("misalign_err", 64'(addr_err), 64'h1);
        step();
        check("misalign_err_pulse", 64'(addr_err), 64'h0);

        // Wrap at the top of the address space.
        do_redirect(2'b11, 32'hFFFF_FFF8);
        step();
        step();
        check("wrap_head_pc", 64'(out_pc), 64'hFFFF_FFFC);
        check("wrap_head_pc4", 64'(out_pc4), 64'h0);
        check("wrap_imem_addr", 64'(imem_addr), 64'h0);

        // Illegal select behaves as sequential PC+4 plus flush.
        do_redirect(2'b00, 32'h0);
        repeat (2) step();

        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            redirect  = ($urandom_range(0, 11) == 0);
            jump_ctrl = 2'($urandom_range(0, 3));
            branch_tgt = 32'h3000 + 32'($urandom_range(0, 255));
            jump_tgt   = 32'h3800 + 32'($urandom_range(0, 255));
            reg_tgt    = $urandom();
            step();
        end
        redirect  = 1'b0;
        en        = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();

        // Asynchronous reset arriving during a redirect.
        do_redirect(2'b10, 32'h4000);
        redirect = 1'b1;
        jump_ctrl = 2'b10;
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'h0);
        check("arst_instr", 64'(out_instr), 64'h0);
        check("arst_pc", 64'(out_pc), 64'h0);
        check("arst_pc4", 64'(out_pc4), 64'h0);
        check("arst_err", 64'(addr_err), 64'h0);
        check("arst_imem_addr", 64'(imem_addr), 64'(RST_PC));
        @(posedge clk);
        #2 reset = 1'b0;
        redirect = 1'b0;
        jump_ctrl = 2'b00;
        check("rel_imem_addr", 64'(imem_addr), 64'(RST_PC));
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
